// File: rtl/card_pkg.sv
// Shared card encoding and score types for the Baccarat datapath.
package card_pkg;

    localparam int unsigned CARD_W  = 4;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned SUM_W   = 5;

    typedef logic [CARD_W-1:0]  card_t;
    typedef logic [SCORE_W-1:0] score_t;

    localparam card_t CARD_NONE  = CARD_W'(0);
    localparam card_t CARD_ACE   = CARD_W'(1);
    localparam card_t CARD_NINE  = CARD_W'(9);
    localparam card_t CARD_TEN   = CARD_W'(10);
    localparam card_t CARD_JACK  = CARD_W'(11);
    localparam card_t CARD_QUEEN = CARD_W'(12);
    localparam card_t CARD_KING  = CARD_W'(13);

endpackage

// File: rtl/card_value.sv
// Maps a card code to its Baccarat point value; tens, faces and unused codes score 0.
module card_value
    import card_pkg::*;
(
    input  card_t        card,
    output logic [3:0]   value
);

    always_comb begin
        value = '0;
        if (card >= CARD_ACE && card <= CARD_NINE) begin
            value = card;
        end
    end

endmodule

// File: rtl/score_hand.sv
// Baccarat hand scorer: combinational score mod 10 plus one registered copy for the displays.
module score_hand
    import card_pkg::*;
(
    input  logic   slow_clock,
    input  logic   reset,
    input  card_t  card1,
    input  card_t  card2,
    input  card_t  card3,
    output score_t total,
    output score_t total_q
);

    logic [3:0]       value1;
    logic [3:0]       value2;
    logic [3:0]       value3;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] reduced;
    score_t           score_d;
    score_t           score_q;

    card_value u_value1 (.card(card1), .value(value1));
    card_value u_value2 (.card(card2), .value(value2));
    card_value u_value3 (.card(card3), .value(value3));

    // Sum is at most 27, so two compare/subtract steps cover the modulo.
    always_comb begin
        sum     = SUM_W'(value1) + SUM_W'(value2) + SUM_W'(value3);
        reduced = sum;
        if (sum >= SUM_W'(20)) begin
            reduced = sum - SUM_W'(20);
        end else if (sum >= SUM_W'(10)) begin
            reduced = sum - SUM_W'(10);
        end
        total   = SCORE_W'(reduced);
        score_d = total;
    end

    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign total_q = score_q;

endmodule

// File: tb/tb_score_hand.sv
// Scoreboard bench for score_hand: directed hands, exhaustive sweep and registered-score timing.
module tb_score_hand;
    import card_pkg::*;

    logic   slow_clock;
    logic   reset;
    card_t  card1;
    card_t  card2;
    card_t  card3;
    score_t total;
    score_t total_q;

    int unsigned n_checks;
    int unsigned n_errors;
    int          exp_total_q[$];
    int          exp_reg_q[$];

    score_hand dut (
        .slow_clock(slow_clock),
        .reset     (reset),
        .card1     (card1),
        .card2     (card2),
        .card3     (card3),
        .total     (total),
        .total_q   (total_q)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cards %0d %0d %0d)",
                     tag, got, exp, card1, card2, card3);
        end
    endtask

    function automatic int ref_points(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int ref_score(input int a, input int b, input int c);
        return (ref_points(a) + ref_points(b) + ref_points(c)) % 10;
    endfunction

    task automatic drive(input int a, input int b, input int c);
        card1 = CARD_W'(a);
        card2 = CARD_W'(b);
        card3 = CARD_W'(c);
    endtask

    // Directed hand: expected score comes from the hand table, not the model.
    task automatic hand(input string tag, input int a, input int b, input int c, input int exp);
        @(negedge slow_clock);
        drive(a, b, c);
        exp_total_q.push_back(exp);
        #1;
        check_eq(tag, int'(total), exp_total_q.pop_front());
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        drive(0, 0, 0);

        // Asynchronous reset before any clock edge.
        #2 reset = 1'b1;
        #1 check_eq("reset_no_edge", int'(total_q), 0);

        hand("2+3+4",    2,  3,  4, 9);
        hand("A+2+3",    1,  2,  3, 6);
        hand("3+4+5",    3,  4,  5, 2);
        hand("5+6+7",    5,  6,  7, 8);
        hand("7+8+9",    7,  8,  9, 4);
        hand("10+A+3",  10,  1,  3, 4);
        hand("10+J+Q",  10, 11, 12, 0);
        hand("J+Q+K",   11, 12, 13, 0);
        hand("Q+K+10",  12, 13, 10, 0);
        hand("K+10+J",  13, 10, 11, 0);
        hand("9+10+J",   9, 10, 11, 9);
        hand("7+7+7",    7,  7,  7, 1);
        hand("8+8+8",    8,  8,  8, 4);
        hand("9+9+9",    9,  9,  9, 7);
        hand("9+A+0",    9,  1,  0, 0);
        hand("1+3+3",    1,  3,  3, 7);
        hand("2+2+4",    2,  2,  4, 8);
        hand("0+0+0",    0,  0,  0, 0);
        hand("14+15+5", 14, 15,  5, 5);
        check_eq("reset_holds", int'(total_q), 0);

        // Exhaustive sweep against the reference model; reset still held.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 16; c++) begin
                    drive(a, b, c);
                    exp_total_q.push_back(ref_score(a, b, c));
                    #1;
                    check_eq("sweep", int'(total), exp_total_q.pop_front());
                    check_eq("sweep_range", int'(total > 4'd9), 0);
                end
            end
        end

        // Registered score: load, hold between edges, async clear.
        @(negedge slow_clock);
        reset = 1'b0;
        drive(5, 6, 7);
        exp_reg_q.push_back(8);
        @(posedge slow_clock);
        #1 check_eq("total_q_load", int'(total_q), exp_reg_q.pop_front());

        drive(2, 3, 4);
        exp_total_q.push_back(9);
        exp_reg_q.push_back(8);
        #1;
        check_eq("total_new", int'(total), exp_total_q.pop_front());
        check_eq("total_q_hold", int'(total_q), exp_reg_q.pop_front());

        #1 reset = 1'b1;
        exp_total_q.push_back(9);
        exp_reg_q.push_back(0);
        #1;
        check_eq("total_q_async_clr", int'(total_q), exp_reg_q.pop_front());
        check_eq("total_during_reset", int'(total), exp_total_q.pop_front());

        exp_reg_q.push_back(0);
        @(posedge slow_clock);
        #1 check_eq("total_q_held_in_reset", int'(total_q), exp_reg_q.pop_front());

        @(negedge slow_clock);
        reset = 1'b0;
        exp_reg_q.push_back(9);
        @(posedge slow_clock);
        #1 check_eq("total_q_after_release", int'(total_q), exp_reg_q.pop_front());

        check_eq("queues_drained", exp_total_q.size() + exp_reg_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
